// File: rtl/divider_pkg.sv
// Shared types and constants for the RV64M divide/remainder unit.
// Holds the operation encoding, FSM states and iteration counts.
package divider_pkg;

    typedef enum logic [2:0] {
        DIV_DIV   = 3'b000,
        DIV_DIVU  = 3'b001,
        DIV_REM   = 3'b010,
        DIV_REMU  = 3'b011,
        DIV_DIVW  = 3'b100,
        DIV_DIVUW = 3'b101,
        DIV_REMW  = 3'b110,
        DIV_REMUW = 3'b111
    } div_type_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_FINISH
    } div_state_t;

    localparam int DIV_ITER_64 = 64;
    localparam int DIV_ITER_32 = 32;

    function automatic logic op_is_w(input div_type_t t);
        return t[2];
    endfunction

    function automatic logic op_is_rem(input div_type_t t);
        return t[1];
    endfunction

    function automatic logic op_is_signed(input div_type_t t);
        return ~t[0];
    endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
// Ports: clk, reset_n, start, flush, dividend, divisor, div_type -> result, done, busy.
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [2:0]      div_type,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy
);

    localparam int HW = XLEN / 2;

    div_state_t      state_q, state_d;
    div_type_t       op_q, op_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // Operand preparation on the live inputs
    div_type_t       in_op;
    logic            in_w, in_sgn;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
    logic            a_neg, b_neg, div_zero, ovf;

    always_comb begin
        in_op  = div_type_t'(div_type);
        in_w   = op_is_w(in_op);
        in_sgn = op_is_signed(in_op);
        a_ext  = dividend;
        b_ext  = divisor;
        if (in_w) begin
            a_ext = {{HW{in_sgn & dividend[HW-1]}}, dividend[HW-1:0]};
            b_ext = {{HW{in_sgn & divisor[HW-1]}}, divisor[HW-1:0]};
        end
        a_neg    = in_sgn & a_ext[XLEN-1];
        b_neg    = in_sgn & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        min_neg  = in_w ? {{(HW + 1){1'b1}}, {(HW - 1){1'b0}}}
                        : {1'b1, {(XLEN - 1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = in_sgn & (b_ext == '1) & (a_ext == min_neg);
    end

    // One restoring step: the borrow bit of the 65-bit subtract decides
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] step_quo, step_rem;

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
        step_rem = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    end

    // Sign fixup and W extension of the final value
    logic [XLEN-1:0] q_fix, r_fix, sel, fin;

    always_comb begin
        q_fix = negq_q ? -quo_q : quo_q;
        r_fix = negr_q ? -rem_q : rem_q;
        sel   = op_is_rem(op_q) ? r_fix : q_fix;
        fin   = op_is_w(op_q) ? {{HW{sel[HW-1]}}, sel[HW-1:0]} : sel;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d   = in_op;
                        busy_d = 1'b1;
                        dvs_d  = b_abs;
                        cnt_d  = in_w ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64);
                        rem_d  = '0;
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                        // Specials preload the final raw values and skip iteration
                        if (div_zero) begin
                            quo_d   = '1;
                            rem_d   = a_ext;
                            state_d = S_FINISH;
                        end else if (ovf) begin
                            quo_d   = a_ext;
                            state_d = S_FINISH;
                        end else begin
                            // W operands sit in the top half so they shift out first
                            quo_d   = in_w ? {a_abs[HW-1:0], {HW{1'b0}}} : a_abs;
                            negq_d  = a_neg ^ b_neg;
                            negr_d  = a_neg;
                            state_d = S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = S_FINISH;
                    end
                end
                S_FINISH: begin
                    result_d = fin;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= DIV_DIV;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the RV64M divider.
// Drives ops on negedges, checks result, latency, pulse and busy on negedges.
module tb_divider;
    import divider_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic [2:0]  div_type = '0;
    logic [63:0] result;
    logic        done;
    logic        busy;

    divider #(.XLEN(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .flush(flush),
        .dividend(dividend),
        .divisor(divisor),
        .div_type(div_type),
        .result(result),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          c;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_done = 1'b0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] t,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic        sg, rm;
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        sg = ~t[0];
        rm = t[1];
        if (t[2]) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) r32 = rm ? a32 : 32'hFFFF_FFFF;
            else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = rm ? 32'd0 : a32;
            else if (sg && rm) r32 = $signed(a32) % $signed(b32);
            else if (sg) r32 = $signed(a32) / $signed(b32);
            else if (rm) r32 = a32 % b32;
            else r32 = a32 / b32;
            r64 = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) r64 = rm ? a : '1;
            else if (sg && a == 64'h8000_0000_0000_0000 && b == '1)
                r64 = rm ? 64'd0 : a;
            else if (sg && rm) r64 = $signed(a) % $signed(b);
            else if (sg) r64 = $signed(a) / $signed(b);
            else if (rm) r64 = a % b;
            else r64 = a / b;
        end
        return r64;
    endfunction

    function automatic int latency(input logic [2:0] t,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        logic [63:0] bx;
        logic [63:0] ax;
        bx = t[2] ? {{32{~t[0] & b[31]}}, b[31:0]} : b;
        ax = t[2] ? {{32{~t[0] & a[31]}}, a[31:0]} : a;
        if (bx == 64'd0) return 2;
        if (~t[0] && bx == '1 &&
            ax == (t[2] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            return 2;
        return t[2] ? 34 : 66;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_done) check("done_pulse", 64'(done), 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", result, mon_e.res);
                    check("latency", 64'(cyc - mon_e.c), 64'(mon_e.lat));
                    check("busy_at_done", 64'(busy), 64'd0);
                    last_res = mon_e.res;
                end
            end else if (sb.size() > 0 && cyc > sb[0].c) begin
                check("busy", 64'(busy), 64'd1);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [2:0] t, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp,
                         input int lat, input bit push);
        div_type = t;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sb.push_back('{res: exp, lat: lat, c: cyc});
        @(negedge clk);
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        div_type = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("timeout", 64'd1, 64'd0);
    endtask

    task automatic run(input logic [2:0] t, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int lat);
        issue(t, a, b, exp, lat, 1'b1);
        wait_done();
    endtask

    logic [2:0]  rt;
    logic [63:0] ra, rb;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run(DIV_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 66);
        run(DIV_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 66);
        run(DIV_DIVU, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run(DIV_REMU, 64'd100, 64'd0, 64'd100, 2);
        run(DIV_DIV, 64'h8000_0000_0000_0000, '1,
            64'h8000_0000_0000_0000, 2);
        run(DIV_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 2);
        run(DIV_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 2);
        run(DIV_DIVUW, 64'h1234_5678_FFFF_FFFE, 64'd2,
            64'h0000_0000_7FFF_FFFF, 34);
        run(DIV_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 34);
        run(DIV_DIVW, 64'd5, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 2);
        run(DIV_REMUW, 64'hABCD_0000_8000_0001, 64'd0,
            64'hFFFF_FFFF_8000_0001, 2);

        for (int i = 0; i < 10; i++) begin
            rt = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 60);
            rb[0] = 1'b1;
            run(rt, ra, rb, model(rt, ra, rb), latency(rt, ra, rb));
        end

        issue(DIV_DIVU, 64'd1000, 64'd7, 64'd142, 66, 1'b1);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        div_type = DIV_DIVU;
        dividend = 64'd5;
        divisor  = 64'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        run(DIV_REMU, 64'd1000, 64'd7, 64'd6, 66);

        issue(DIV_DIV, 64'd123456, 64'd3, 64'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        repeat (70) @(negedge clk);
        check("flush_result", result, last_res);
        check("flush_done", 64'(done), 64'd0);

        start    = 1'b1;
        flush    = 1'b1;
        div_type = DIV_DIVU;
        dividend = 64'd9;
        divisor  = 64'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("flush_start_result", result, last_res);

        issue(DIV_DIV, 64'd999, 64'd4, 64'd0, 0, 1'b0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_result", result, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(DIV_DIVU, 64'd1000, 64'd7, 64'd142, 66);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
